// File: rtl/dec_pkg.sv
// dec_pkg: shared mode encodings and FSM state type for the one-hot decoder.
package dec_pkg;
  localparam logic [1:0] MODE_PULSE = 2'b00;
  localparam logic [1:0] MODE_HOLD  = 2'b01;
  localparam logic [1:0] MODE_SWEEP = 2'b10;
  typedef enum logic {IDLE, SWEEP} state_t;
endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: combinational SEL_W-to-2^SEL_W one-hot decoder.
module dec_onehot #(
  parameter int SEL_W = 5
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   oh
);
  assign oh = {{(2**SEL_W-1){1'b0}}, 1'b1} << sel;
endmodule

// File: rtl/dec_onehot_seq.sv
// dec_onehot_seq: registered one-hot decoder with pulse, hold and sweep modes,
// valid/ready command port and per-output write protection.
module dec_onehot_seq
  import dec_pkg::*;
#(
  parameter int SEL_W = 5,
  parameter logic [2**SEL_W-1:0] PROTECT_MASK = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     sel,
  input  logic [1:0]           mode,
  input  logic [SEL_W-1:0]     sweep_last,
  input  logic                 en,
  output logic [2**SEL_W-1:0]  out,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 err
);
  localparam int OUT_W = 2**SEL_W;
  localparam int CW = SEL_W + 1;
  state_t state, state_n;
  logic [CW-1:0] idx, idx_n, rem, rem_n, step;
  logic [OUT_W-1:0] oh, out_n;
  logic [SEL_W-1:0] dsel, span;
  logic acc, prot, held, held_n, valid_n, last_n, err_n;
  assign in_ready = (state == IDLE) && en;
  assign acc = in_valid && in_ready;
  assign step = idx + CW'(1);
  assign dsel = acc ? sel : step[SEL_W-1:0];
  assign prot = PROTECT_MASK[dsel];
  assign span = sweep_last - sel;
  dec_onehot #(.SEL_W(SEL_W)) u_dec (.sel(dsel), .oh(oh));
  // rem counts beats still to come after the one currently on out
  always_comb begin
    state_n = state;
    idx_n = idx;
    rem_n = rem;
    held_n = held;
    out_n = held ? out : '0;
    valid_n = held;
    last_n = 1'b0;
    err_n = 1'b0;
    if (!en) begin
      state_n = IDLE;
      held_n = 1'b0;
      out_n = '0;
      valid_n = 1'b0;
    end else if (acc) begin
      idx_n = {1'b0, sel};
      rem_n = {1'b0, span};
      out_n = prot ? '0 : oh;
      valid_n = 1'b1;
      err_n = prot;
      held_n = (mode == MODE_HOLD);
      state_n = (mode == MODE_SWEEP) ? SWEEP : IDLE;
      last_n = (mode != MODE_SWEEP) || (span == '0);
    end else if (state == SWEEP) begin
      state_n = (rem == '0) ? IDLE : SWEEP;
      if (rem != '0) begin
        idx_n = step;
        rem_n = rem - CW'(1);
        out_n = prot ? '0 : oh;
        valid_n = 1'b1;
        err_n = prot;
        last_n = (rem == CW'(1));
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      rem <= '0;
      held <= 1'b0;
      out <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      rem <= rem_n;
      held <= held_n;
      out <= out_n;
      out_valid <= valid_n;
      out_last <= last_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_dec_onehot_seq.sv
// tb_dec_onehot_seq: table-driven and directed checks of dec_onehot_seq (SEL_W=5, bit 0 protected).
module tb_dec_onehot_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, en = 1'b1;
  logic in_ready, out_valid, out_last, err;
  logic [4:0] sel = '0, sweep_last = '0;
  logic [1:0] mode = '0;
  logic [31:0] out;
  int checks = 0, failures = 0;
  typedef struct {
    logic v; logic [4:0] s; logic [1:0] m; logic e;
    logic [31:0] o; logic ov; logic ol; logic er; logic rd;
  } vec_t;
  vec_t tv[20];
  logic [31:0] sw_o[4];
  logic sw_l[4], sw_e[4];
  dec_onehot_seq #(.SEL_W(5), .PROTECT_MASK(32'h0000_0001)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .sweep_last(sweep_last), .en(en),
    .out(out), .out_valid(out_valid), .out_last(out_last), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input logic v, input logic [4:0] s, input logic [1:0] m, input logic [4:0] l);
    in_valid = v; sel = s; mode = m; sweep_last = l;
  endtask
  function automatic logic [31:0] exp_oh(input int i);
    logic [31:0] one;
    one = 32'h1;
    return (i % 32 == 0) ? 32'h0 : one << (i % 32);
  endfunction
  initial begin
    tv[0]  = '{1, 7, 2'b00, 1, 32'h0000_0080, 1, 1, 0, 1};
    tv[1]  = '{0, 0, 2'b00, 1, 32'h0000_0000, 0, 0, 0, 1};
    tv[2]  = '{1, 31, 2'b01, 1, 32'h8000_0000, 1, 1, 0, 1};
    tv[3]  = '{0, 0, 2'b00, 1, 32'h8000_0000, 1, 0, 0, 1};
    tv[4]  = '{0, 0, 2'b00, 1, 32'h8000_0000, 1, 0, 0, 1};
    tv[5]  = '{1, 3, 2'b01, 1, 32'h0000_0008, 1, 1, 0, 1};
    tv[6]  = '{1, 0, 2'b00, 1, 32'h0000_0000, 1, 1, 1, 1};
    tv[7]  = '{0, 0, 2'b00, 1, 32'h0000_0000, 0, 0, 0, 1};
    tv[8]  = '{1, 0, 2'b01, 1, 32'h0000_0000, 1, 1, 1, 1};
    tv[9]  = '{0, 0, 2'b00, 1, 32'h0000_0000, 1, 0, 0, 1};
    tv[10] = '{1, 5, 2'b11, 1, 32'h0000_0020, 1, 1, 0, 1};
    tv[11] = '{0, 0, 2'b00, 1, 32'h0000_0000, 0, 0, 0, 1};
    tv[12] = '{1, 9, 2'b01, 1, 32'h0000_0200, 1, 1, 0, 1};
    tv[13] = '{1, 4, 2'b00, 0, 32'h0000_0000, 0, 0, 0, 0};
    tv[14] = '{0, 0, 2'b00, 1, 32'h0000_0000, 0, 0, 0, 1};
    tv[15] = '{1, 1, 2'b00, 1, 32'h0000_0002, 1, 1, 0, 1};
    tv[16] = '{1, 2, 2'b00, 1, 32'h0000_0004, 1, 1, 0, 1};
    tv[17] = '{1, 3, 2'b00, 1, 32'h0000_0008, 1, 1, 0, 1};
    tv[18] = '{1, 4, 2'b00, 1, 32'h0000_0010, 1, 1, 0, 1};
    tv[19] = '{0, 0, 2'b00, 1, 32'h0000_0000, 0, 0, 0, 1};
    sw_o = '{32'h4000_0000, 32'h8000_0000, 32'h0, 32'h2};
    sw_l = '{0, 0, 0, 1};
    sw_e = '{0, 0, 1, 0};
    #12;
    chk("reset_out", out, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_last", out_last, 0);
    chk("reset_err", err, 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      cmd(tv[i].v, tv[i].s, tv[i].m, 5'd0);
      en = tv[i].e;
      step();
      chk($sformatf("vec%0d_out", i), out, tv[i].o);
      chk($sformatf("vec%0d_valid", i), out_valid, tv[i].ov);
      chk($sformatf("vec%0d_last", i), out_last, tv[i].ol);
      chk($sformatf("vec%0d_err", i), err, tv[i].er);
      chk($sformatf("vec%0d_ready", i), in_ready, tv[i].rd);
    end
    cmd(1, 30, 2'b10, 1);
    step();
    cmd(0, 0, 2'b00, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sw4_b%0d_out", k), out, sw_o[k]);
      chk($sformatf("sw4_b%0d_valid", k), out_valid, 1);
      chk($sformatf("sw4_b%0d_last", k), out_last, sw_l[k]);
      chk($sformatf("sw4_b%0d_err", k), err, sw_e[k]);
      chk($sformatf("sw4_b%0d_ready", k), in_ready, 0);
      step();
    end
    chk("sw4_end_valid", out_valid, 0);
    chk("sw4_end_ready", in_ready, 1);
    cmd(1, 5, 2'b10, 5);
    step();
    cmd(0, 0, 2'b00, 0);
    chk("sw1_out", out, 32'h20);
    chk("sw1_last", out_last, 1);
    chk("sw1_ready", in_ready, 0);
    step();
    chk("sw1_end_valid", out_valid, 0);
    chk("sw1_end_ready", in_ready, 1);
    cmd(1, 4, 2'b10, 3);
    step();
    cmd(0, 0, 2'b00, 0);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("sw32_b%0d_out", k), out, exp_oh(4 + k));
      chk($sformatf("sw32_b%0d_last", k), out_last, k == 31);
      chk($sformatf("sw32_b%0d_valid", k), out_valid, 1);
      step();
    end
    chk("sw32_end_valid", out_valid, 0);
    cmd(1, 0, 2'b10, 31);
    step();
    cmd(0, 0, 2'b00, 0);
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("swab_b%0d_out", k), out, exp_oh(k));
      chk($sformatf("swab_b%0d_err", k), err, k == 0);
      chk($sformatf("swab_b%0d_last", k), out_last, 0);
      if (k < 10) step();
    end
    en = 1'b0;
    step();
    chk("swab_abort_out", out, 0);
    chk("swab_abort_valid", out_valid, 0);
    chk("swab_abort_last", out_last, 0);
    chk("swab_abort_ready", in_ready, 0);
    step();
    chk("swab_idle_valid", out_valid, 0);
    en = 1'b1;
    #1;
    chk("swab_ready_back", in_ready, 1);
    cmd(1, 2, 2'b00, 0);
    step();
    cmd(0, 0, 2'b00, 0);
    chk("post_abort_out", out, 32'h4);
    cmd(1, 6, 2'b01, 0);
    step();
    cmd(0, 0, 2'b00, 0);
    chk("rst_hold_out", out, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", out, 0);
    chk("rst_async_valid", out_valid, 0);
    #3;
    rst_n = 1'b1;
    step();
    chk("rst_after_valid", out_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
